// File: rtl/u_adc_dly_cal_pkg.sv
// ---------------------------------------------------------------------------
// u_adc_dly_cal_pkg
// Shared constants for the LVDS ADC IDELAY calibration engine: lane count,
// tap width, phase lengths, fallback tap and the FSM state encoding.
// No ports.
// ---------------------------------------------------------------------------
package u_adc_dly_cal_pkg;

   localparam int unsigned CAL_NUM_LANES   = 7;
   localparam int unsigned CAL_TAP_W       = 5;
   localparam int unsigned CAL_SETTLE_CYC  = 16;
   localparam int unsigned CAL_SAMPLE_CYC  = 64;
   localparam int unsigned CAL_DEFAULT_TAP = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_CENTER,
      ST_APPLY,
      ST_SETTLE_F,
      ST_DONE
   } cal_state_t;

endpackage

// File: rtl/u_adc_dly_cal_if.sv
// ---------------------------------------------------------------------------
// u_adc_dly_cal_if
// Per-lane IDELAY load bus between the calibration engine (master) and the
// delay elements (slave).
//   up_dld     : per-lane 1-cycle tap-load strobe          (master -> slave)
//   up_dwdata  : tap values, lane k in [k*TAP_W +: TAP_W]  (master -> slave)
//   up_drdata  : tap readback, same packing                (slave -> master)
// ---------------------------------------------------------------------------
interface u_adc_dly_cal_if #(
   parameter int unsigned NUM_LANES = 7,
   parameter int unsigned TAP_W     = 5
);

   logic [NUM_LANES-1:0]       up_dld;
   logic [TAP_W*NUM_LANES-1:0] up_dwdata;
   logic [TAP_W*NUM_LANES-1:0] up_drdata;

   modport master (
      output up_dld,
      output up_dwdata,
      input  up_drdata
   );

   modport slave (
      input  up_dld,
      input  up_dwdata,
      output up_drdata
   );

endinterface

// File: rtl/u_adc_dly_cal_dly_eye_track.sv
// ---------------------------------------------------------------------------
// dly_eye_track
// Tracks the current run of passing taps and the widest run seen so far for
// one lane sweep.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of all run/best state (start of a lane)
//   step       : one tap result is presented on pass/tap
//   pass       : the tap passed
//   last       : this is the final tap; close the run after updating it
//   tap        : tap being evaluated
//   best_start : first tap of the widest window
//   best_len   : width of the widest window (0 = no passing tap)
// ---------------------------------------------------------------------------
module dly_eye_track #(
   parameter int unsigned TAP_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step,
   input  logic             pass,
   input  logic             last,
   input  logic [TAP_W-1:0] tap,
   output logic [TAP_W-1:0] best_start,
   output logic [TAP_W:0]   best_len
);

   logic [TAP_W-1:0] run_start;
   logic [TAP_W:0]   run_len;
   logic [TAP_W-1:0] run_start_n;
   logic [TAP_W:0]   run_len_n;
   logic             close_run;

   // Run state after this tap, before any close.
   always_comb begin
      run_start_n = run_start;
      run_len_n   = run_len;
      if (pass) begin
         run_len_n = run_len + (TAP_W+1)'(1);
         if (run_len == '0) begin
            run_start_n = tap;
         end
      end
   end

   assign close_run = !pass || last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_start  <= '0;
         run_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (clr) begin
         run_start  <= '0;
         run_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
      end else if (step) begin
         if (close_run) begin
            // Strict compare: an equal-width later window never replaces the earlier one.
            if (run_len_n > best_len) begin
               best_start <= run_start_n;
               best_len   <= run_len_n;
            end
            run_len <= '0;
         end else begin
            run_start <= run_start_n;
            run_len   <= run_len_n;
         end
      end
   end

endmodule

// File: rtl/u_adc_dly_cal.sv
// ---------------------------------------------------------------------------
// u_adc_dly_cal
// Automatic IDELAY calibration for the LVDS ADC capture lanes. Per lane it
// sweeps every tap, compares captured data with the training pattern, finds
// the widest passing window and loads its centre.
//   i_delay_clk    : clock (IDELAYCTRL reference)
//   i_clr          : asynchronous active-high reset
//   i_start        : 1-cycle start pulse, ignored while busy
//   i_delay_locked : IDELAYCTRL ready
//   i_pattern      : expected captured word, 2 bits per lane
//   i_lane_data    : captured word, 2 bits per lane
//   up             : IDELAY load bus (master side)
//   o_busy         : calibration in progress
//   o_done         : sticky completion flag, cleared by i_start
//   o_abort        : sticky lock-lost flag, cleared by i_start
//   o_err          : per lane, no passing tap or readback mismatch
//   o_tap          : final tap per lane, lane k in [k*TAP_W +: TAP_W]
// ---------------------------------------------------------------------------
module u_adc_dly_cal
   import u_adc_dly_cal_pkg::*;
#(
   parameter int unsigned NUM_LANES   = CAL_NUM_LANES,
   parameter int unsigned TAP_W       = CAL_TAP_W,
   parameter int unsigned SETTLE_CYC  = CAL_SETTLE_CYC,
   parameter int unsigned SAMPLE_CYC  = CAL_SAMPLE_CYC,
   parameter int unsigned DEFAULT_TAP = CAL_DEFAULT_TAP
) (
   input  logic                       i_delay_clk,
   input  logic                       i_clr,
   input  logic                       i_start,
   input  logic                       i_delay_locked,
   input  logic [2*NUM_LANES-1:0]     i_pattern,
   input  logic [2*NUM_LANES-1:0]     i_lane_data,
   u_adc_dly_cal_if.master            up,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_abort,
   output logic [NUM_LANES-1:0]       o_err,
   output logic [TAP_W*NUM_LANES-1:0] o_tap
);

   localparam int unsigned LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned MAX_CYC = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   cal_state_t                 state;
   logic [LANE_W-1:0]          lane;
   logic [TAP_W-1:0]           tap;
   logic [CNT_W-1:0]           cnt;
   logic                       fail;
   logic [NUM_LANES-1:0]       dld;
   logic [TAP_W*NUM_LANES-1:0] dwdata;

   logic [TAP_W-1:0] best_start;
   logic [TAP_W:0]   best_len;
   logic [TAP_W-1:0] rb_tap;
   logic [TAP_W-1:0] center_tap;
   logic             lane_ok;
   logic             settle_last;
   logic             sample_last;
   logic             lock_lost;
   logic             eye_clr;
   logic             eye_step;

   assign up.up_dld    = dld;
   assign up.up_dwdata = dwdata;

   assign rb_tap      = up.up_drdata[lane*TAP_W +: TAP_W];
   assign lane_ok     = (i_lane_data[lane*2 +: 2] == i_pattern[lane*2 +: 2]);
   assign settle_last = (cnt == CNT_W'(SETTLE_CYC - 1));
   assign sample_last = (cnt == CNT_W'(SAMPLE_CYC - 1));
   assign lock_lost   = (state != ST_IDLE) && (state != ST_WAIT_RDY) && !i_delay_locked;

   // Eye state is wiped at the start of every run and once the lane's centre is applied.
   assign eye_clr  = (state == ST_WAIT_RDY) || (state == ST_APPLY);
   assign eye_step = (state == ST_EVAL);

   // best_start + floor(best_len/2); a window always ends by the top tap, so no overflow.
   assign center_tap = (best_len == '0) ? TAP_W'(DEFAULT_TAP)
                                        : best_start + best_len[TAP_W:1];

   dly_eye_track #(
      .TAP_W (TAP_W)
   ) u_eye (
      .clk        (i_delay_clk),
      .rst        (i_clr),
      .clr        (eye_clr),
      .step       (eye_step),
      .pass       (!fail),
      .last       (tap == '1),
      .tap        (tap),
      .best_start (best_start),
      .best_len   (best_len)
   );

   // Load strobes are issued on the edge entering LOAD/APPLY, so o_up_dld is
   // high exactly while the FSM sits in that one-cycle state.
   always_ff @(posedge i_delay_clk or posedge i_clr) begin
      if (i_clr) begin
         state   <= ST_IDLE;
         lane    <= '0;
         tap     <= '0;
         cnt     <= '0;
         fail    <= 1'b0;
         dld     <= '0;
         dwdata  <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_abort <= 1'b0;
         o_err   <= '0;
         o_tap   <= '0;
      end else begin
         dld <= '0;
         if (lock_lost) begin
            o_abort <= 1'b1;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     o_done  <= 1'b0;
                     o_abort <= 1'b0;
                     o_err   <= '0;
                     lane    <= '0;
                     tap     <= '0;
                     o_busy  <= 1'b1;
                     state   <= ST_WAIT_RDY;
                  end
               end
               ST_WAIT_RDY: begin
                  if (i_delay_locked) begin
                     dld[lane]                       <= 1'b1;
                     dwdata[lane*TAP_W +: TAP_W]     <= tap;
                     state                           <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  cnt   <= '0;
                  state <= ST_SETTLE;
               end
               ST_SETTLE: begin
                  cnt <= cnt + CNT_W'(1);
                  if (settle_last) begin
                     if (rb_tap != tap) begin
                        o_err[lane] <= 1'b1;
                     end
                     cnt   <= '0;
                     fail  <= 1'b0;
                     state <= ST_SAMPLE;
                  end
               end
               ST_SAMPLE: begin
                  cnt <= cnt + CNT_W'(1);
                  if (!lane_ok) begin
                     fail <= 1'b1;
                  end
                  if (sample_last) begin
                     state <= ST_EVAL;
                  end
               end
               ST_EVAL: begin
                  if (tap == '1) begin
                     state <= ST_CENTER;
                  end else begin
                     tap                         <= tap + TAP_W'(1);
                     dld[lane]                   <= 1'b1;
                     dwdata[lane*TAP_W +: TAP_W] <= tap + TAP_W'(1);
                     state                       <= ST_LOAD;
                  end
               end
               ST_CENTER: begin
                  if (best_len == '0) begin
                     o_err[lane] <= 1'b1;
                  end
                  tap                         <= center_tap;
                  dld[lane]                   <= 1'b1;
                  dwdata[lane*TAP_W +: TAP_W] <= center_tap;
                  o_tap[lane*TAP_W +: TAP_W]  <= center_tap;
                  state                       <= ST_APPLY;
               end
               ST_APPLY: begin
                  cnt   <= '0;
                  state <= ST_SETTLE_F;
               end
               ST_SETTLE_F: begin
                  cnt <= cnt + CNT_W'(1);
                  if (settle_last) begin
                     if (rb_tap != tap) begin
                        o_err[lane] <= 1'b1;
                     end
                     cnt <= '0;
                     if (lane == LANE_W'(NUM_LANES - 1)) begin
                        state <= ST_DONE;
                     end else begin
                        lane                              <= lane + LANE_W'(1);
                        tap                               <= '0;
                        dld[lane + LANE_W'(1)]            <= 1'b1;
                        dwdata[(lane + LANE_W'(1))*TAP_W +: TAP_W] <= '0;
                        state                             <= ST_LOAD;
                     end
                  end
               end
               ST_DONE: begin
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_u_adc_dly_cal.sv
module tb_u_adc_dly_cal;

   localparam int NL = 7;
   localparam int TW = 5;

   logic              clk = 1'b0;
   logic              clr;
   logic              start;
   logic              locked;
   logic [2*NL-1:0]   pattern;
   logic [2*NL-1:0]   lane_data;
   logic              busy;
   logic              done;
   logic              abort;
   logic [NL-1:0]     err;
   logic [TW*NL-1:0]  otap;
   logic [TW*NL-1:0]  drdata;

   // Link model: per-lane passing-tap mask, readback-stuck flags, loaded taps.
   logic [31:0]       win [NL];
   logic [NL-1:0]     stuck;
   logic [TW-1:0]     mtap [NL];

   int total = 0;
   int bad   = 0;
   int load_cnt;
   int onehot_bad;
   int consec_bad;
   logic [NL-1:0] prev_dld;

   always #5 clk = ~clk;

   u_adc_dly_cal_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

   assign bus.up_drdata = drdata;

   u_adc_dly_cal dut (
      .i_delay_clk    (clk),
      .i_clr          (clr),
      .i_start        (start),
      .i_delay_locked (locked),
      .i_pattern      (pattern),
      .i_lane_data    (lane_data),
      .up             (bus),
      .o_busy         (busy),
      .o_done         (done),
      .o_abort        (abort),
      .o_err          (err),
      .o_tap          (otap)
   );

   always_comb begin
      lane_data = '0;
      drdata    = '0;
      for (int k = 0; k < NL; k++) begin
         lane_data[2*k +: 2] = win[k][mtap[k]] ? pattern[2*k +: 2] : ~pattern[2*k +: 2];
         drdata[TW*k +: TW]  = stuck[k] ? '0 : mtap[k];
      end
   end

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int k = 0; k < NL; k++) mtap[k] <= '0;
      end else begin
         for (int k = 0; k < NL; k++)
            if (bus.up_dld[k]) mtap[k] <= bus.up_dwdata[TW*k +: TW];
      end
   end

   always @(negedge clk) begin
      if (|bus.up_dld) load_cnt++;
      if ($countones(bus.up_dld) > 1) onehot_bad++;
      if ((|bus.up_dld) && (|prev_dld)) consec_bad++;
      prev_dld = bus.up_dld;
   end

   task automatic pulse_start;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic clear_counts;
      load_cnt   = 0;
      onehot_bad = 0;
      consec_bad = 0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_timeout: got=%0b want=1 after %0d cycles", name, done, n);
      end
   endtask

   task automatic test_reset;
      clr     = 1'b1;
      start   = 1'b0;
      locked  = 1'b1;
      pattern = 14'h2A5C;
      stuck   = '0;
      prev_dld = '0;
      for (int k = 0; k < NL; k++) win[k] = 32'hFFFF_FFFF;
      clear_counts();
      #12;
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got=%0b want=0", busy); end
      total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got=%0b want=0", done); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort: got=%0b want=0", abort); end
      total++; if (err !== '0)     begin bad++; $display("FAIL reset_err: got=%b want=0", err); end
      total++; if (otap !== '0)    begin bad++; $display("FAIL reset_tap: got=%h want=0", otap); end
      total++; if (bus.up_dld !== '0 || bus.up_dwdata !== '0) begin
         bad++; $display("FAIL reset_bus: dld=%b dwdata=%h want 0", bus.up_dld, bus.up_dwdata);
      end
      @(negedge clk) clr = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0 || load_cnt != 0) begin
         bad++; $display("FAIL reset_idle: busy=%0b loads=%0d want 0/0", busy, load_cnt);
      end
   endtask

   task automatic test_ideal;
      logic [TW*NL-1:0] exp_tap;
      exp_tap = {NL{5'd16}};
      for (int k = 0; k < NL; k++) win[k] = 32'hFFFF_FFFF;
      stuck = '0;
      clear_counts();
      pulse_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ideal_busy: got=%0b want=1", busy); end
      wait_done(25000, "ideal");
      total++; if (busy !== 1'b0 || abort !== 1'b0) begin
         bad++; $display("FAIL ideal_flags: busy=%0b abort=%0b want 0/0", busy, abort);
      end
      total++; if (err !== 7'b0) begin bad++; $display("FAIL ideal_err: got=%b want=0000000", err); end
      total++; if (otap !== exp_tap) begin bad++; $display("FAIL ideal_tap: got=%h want=%h", otap, exp_tap); end
      total++; if (bus.up_dwdata !== exp_tap) begin
         bad++; $display("FAIL ideal_dwdata: got=%h want=%h", bus.up_dwdata, exp_tap);
      end
      total++; if (load_cnt != NL*33) begin bad++; $display("FAIL ideal_loads: got=%0d want=%0d", load_cnt, NL*33); end
      total++; if (onehot_bad != 0 || consec_bad != 0) begin
         bad++; $display("FAIL ideal_dld_onehot: multi=%0d consecutive=%0d want 0/0", onehot_bad, consec_bad);
      end
   endtask

   task automatic test_mixed;
      logic [TW*NL-1:0] exp_tap;
      // lane6..lane0
      exp_tap = {5'd16, 5'd26, 5'd4, 5'd9, 5'd18, 5'd18, 5'd3};
      win[0] = 32'h0070_001C;   // 2..4 and 20..22
      win[1] = 32'h0FFF_FF00;   // 8..27, readback stuck at 0
      win[2] = 32'h0FFF_FF00;   // 8..27
      win[3] = 32'h0000_1FE0;   // 5..12
      win[4] = 32'h0000_00FF;   // 0..7
      win[5] = 32'hFFF0_0000;   // 20..31
      win[6] = 32'h0000_0000;   // never passes
      stuck  = 7'b0000010;
      clear_counts();
      pulse_start();
      total++; if (done !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL mixed_start_clears_done: done=%0b busy=%0b want 0/1", done, busy);
      end
      wait_done(25000, "mixed");
      total++; if (busy !== 1'b0 || abort !== 1'b0) begin
         bad++; $display("FAIL mixed_flags: busy=%0b abort=%0b want 0/0", busy, abort);
      end
      total++; if (err !== 7'b1000010) begin bad++; $display("FAIL mixed_err: got=%b want=1000010", err); end
      total++; if (otap !== exp_tap) begin bad++; $display("FAIL mixed_tap: got=%h want=%h", otap, exp_tap); end
      total++; if (bus.up_dwdata !== exp_tap) begin
         bad++; $display("FAIL mixed_dwdata: got=%h want=%h", bus.up_dwdata, exp_tap);
      end
      total++; if (load_cnt != NL*33) begin bad++; $display("FAIL mixed_loads: got=%0d want=%0d", load_cnt, NL*33); end
      total++; if (onehot_bad != 0 || consec_bad != 0) begin
         bad++; $display("FAIL mixed_dld_onehot: multi=%0d consecutive=%0d want 0/0", onehot_bad, consec_bad);
      end
   endtask

   task automatic test_abort;
      logic [TW*NL-1:0] exp_tap;
      int n;
      int loads_at_abort;
      // lanes 0,1 re-calibrated on the ideal link; lanes 2..6 keep earlier results
      exp_tap = {5'd16, 5'd26, 5'd4, 5'd9, 5'd18, 5'd16, 5'd16};
      for (int k = 0; k < NL; k++) win[k] = 32'hFFFF_FFFF;
      stuck  = '0;
      locked = 1'b0;
      clear_counts();
      pulse_start();
      repeat (20) @(negedge clk);
      total++; if (busy !== 1'b1 || load_cnt != 0) begin
         bad++; $display("FAIL abort_wait_rdy: busy=%0b loads=%0d want 1/0", busy, load_cnt);
      end
      locked = 1'b1;
      n = 0;
      while (bus.up_dld[2] !== 1'b1 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      total++; if (bus.up_dld[2] !== 1'b1) begin
         bad++; $display("FAIL abort_reach_lane2: dld=%b want lane2 strobe", bus.up_dld);
      end
      repeat (200) @(negedge clk);
      locked = 1'b0;
      repeat (2) @(negedge clk);
      loads_at_abort = load_cnt;
      total++; if (abort !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL abort_flags: abort=%0b busy=%0b done=%0b want 1/0/0", abort, busy, done);
      end
      total++; if (err !== 7'b0) begin bad++; $display("FAIL abort_err: got=%b want=0000000", err); end
      total++; if (otap !== exp_tap) begin bad++; $display("FAIL abort_tap: got=%h want=%h", otap, exp_tap); end
      total++; if (bus.up_dwdata[9:0] !== {5'd16, 5'd16}) begin
         bad++; $display("FAIL abort_taps_kept: got=%h want=210", bus.up_dwdata[9:0]);
      end
      locked = 1'b1;
      repeat (50) @(negedge clk);
      total++; if (load_cnt != loads_at_abort || busy !== 1'b0) begin
         bad++; $display("FAIL abort_stays_idle: loads=%0d->%0d busy=%0b want no change/0", loads_at_abort, load_cnt, busy);
      end
   endtask

   task automatic test_clr;
      locked = 1'b1;
      pulse_start();
      repeat (300) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_running: busy=%0b want=1", busy); end
      #2 clr = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0) begin
         bad++; $display("FAIL clr_flags: busy=%0b done=%0b abort=%0b want 0/0/0", busy, done, abort);
      end
      total++; if (err !== '0 || otap !== '0) begin
         bad++; $display("FAIL clr_results: err=%b tap=%h want 0/0", err, otap);
      end
      total++; if (bus.up_dld !== '0 || bus.up_dwdata !== '0) begin
         bad++; $display("FAIL clr_bus: dld=%b dwdata=%h want 0/0", bus.up_dld, bus.up_dwdata);
      end
      @(negedge clk) clr = 1'b0;
      clear_counts();
      repeat (5) @(negedge clk);
      total++; if (busy !== 1'b0 || load_cnt != 0) begin
         bad++; $display("FAIL clr_idle_after: busy=%0b loads=%0d want 0/0", busy, load_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_mixed();
      test_abort();
      test_clr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
